mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide synchronous RAM port between instruction fetch (IF) and load/store (MEM).
- Sequences 1/2/4-byte little-endian reads and writes over several cycles.
- Returns assembled data to the requester and drives per-stage stall requests to the pipeline controller.
- Sits between the if/mem stages and the RAM; a taken branch or jump from EX flushes an in-flight fetch.

Parameters:
ADDR_W, 32, RAM address width; requester addresses are truncated to it.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high (`RstEnable`).
if_req_i  in  1  fetch request (level); held until if_done_o.
if_addr_i  in  32  fetch byte address; always a 4-byte read.
if_flush_i  in  1  branch/jump taken in EX; abort the fetch.
mem_req_i  in  1  load/store request (level); held until mem_done_o.
mem_we_i  in  1  1 = store, 0 = load.
mem_len_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
mem_addr_i  in  32  load/store byte address.
mem_wdata_i  in  32  store data; byte k = bits [8k+7:8k].
ram_din_i  in  8  RAM read data; valid the cycle after the address is driven.
ram_addr_o  out  ADDR_W  RAM byte address.
ram_dout_o  out  8  RAM write data.
ram_wr_o  out  1  RAM write strobe.
if_data_o  out  32  fetched instruction; valid while if_done_o is high.
if_done_o  out  1  one-cycle completion pulse for the fetch.
mem_rdata_o  out  32  load data, zero-extended; valid while mem_done_o is high.
mem_done_o  out  1  one-cycle completion pulse for the load/store.
stall_req_if_o  out  1  = if_req_i & ~if_done_o.
stall_req_mem_o  out  1  = mem_req_i & ~mem_done_o.

Behaviour:
- Reset: state IDLE; ram_addr_o, ram_dout_o, if_data_o, mem_rdata_o = 0; ram_wr_o, if_done_o, mem_done_o = 0; byte counter = 0; owner = NONE.
- States:
  - IDLE: sample requests.
  - XFER: drive one byte per cycle.
  - TAIL: reads only; capture the last byte.
  - DONE: pulse done.
- Grant (in IDLE only):
  - mem_req_i beats if_req_i.
  - On grant, latch base address, length L (1/2/4), we, wdata and owner; go to XFER.
  - No preemption once granted.
- XFER, cycle k = 0..L-1:
  - ram_addr_o = base + k (wraps modulo 2^ADDR_W).
  - Store: ram_wr_o = 1, ram_dout_o = wdata byte k.
  - Load: ram_wr_o = 0; ram_din_i is captured into byte k-1 of the assembly register.
  - After k = L-1: a store goes to DONE; a load goes to TAIL, which captures byte L-1.
- DONE: the owner's done pulse is high for exactly 1 cycle with data; then IDLE.
- Latency from the request-sampled cycle t0 to the done cycle:
  - Load of L bytes: t0 + L + 2 (word load = t0+6).
  - Store of L bytes: t0 + L + 1.
- Unused upper bytes of mem_rdata_o are 0; sign extension belongs to the MEM stage.
- ram_wr_o is 0 in every state except store XFER.
- Flush, IF owner in XFER/TAIL: abort, return to IDLE next cycle, no if_done_o, assembly register discarded.
- Flush while MEM is owner: ignored.
- Flush in IDLE: if_req_i is ignored that cycle; mem_req_i is still grantable.
- Flush in DONE with IF owner: if_done_o suppressed.
- Requesters must drop or change their request the cycle after done. The controller treats any request seen in IDLE as new; a held store is rewritten.
- Reset mid-transaction returns to IDLE next edge with all outputs at reset values; a partial store is not completed.

Optional Feature:
MEMCTRL_RR_ARB_EN:
- Defined: a 1-bit last_owner register (reset MEM). If both requests are pending in IDLE and last_owner = MEM, IF is granted; otherwise MEM is granted. last_owner updates at every grant.
- Undefined: fixed MEM priority; no extra register.

Decomposition:
- Shared defines header/package: state encodings (IDLE/XFER/TAIL/DONE), owner codes (NONE/IF/MEM), length codes (`MEM_LEN_B/H/W`), the length-to-byte-count function, `RstEnable`, `ZeroWord`.
- Sub-module mem_ctrl_arb: combinational grant logic with the optional RR state input. The FSM and byte assembly stay in mem_ctrl.

Test Plan:
- IF only: if_addr_i = 0x100, RAM[0x100..0x103] = 13,05,A0,00 -> if_done_o at t0+6, if_data_o = 0x00A00513, ram_wr_o never high.
- Store half: mem_addr_i = 0x2001, wdata = 0x1234ABCD, len = 01 -> writes CD@0x2001 then AB@0x2002, mem_done_o at t0+3, no other writes.
- Simultaneous: IF 0x0 and load byte 0x40 (=0x80) in the same cycle -> mem_done_o first with 0x00000080 at t0+3. IF is granted in the following IDLE; if_done_o 6 cycles after that grant.
- Flush: IF granted, if_flush_i pulsed at t0+3 -> IDLE at t0+4, no if_done_o. A new fetch to 0x200 completes normally.
- Reset mid-store: word store to 0x10, rst high at t0+2 -> only bytes 0x10 and 0x11 written, all outputs 0 the next cycle, state IDLE.
- MEMCTRL_RR_ARB_EN: both requesters held continuously -> grants alternate MEM, IF, MEM, IF. Without the macro, MEM is always granted first.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM port controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StXfer, StTail, StDone} state_e;

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnMem} owner_e;

  localparam logic [1:0]  MemLenB   = 2'b00;
  localparam logic [1:0]  MemLenH   = 2'b01;
  localparam logic [1:0]  MemLenW   = 2'b10;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Byte count of a transfer; the reserved code 11 behaves as a word.
  function automatic logic [2:0] len_bytes(logic [1:0] len);
    case (len)
      MemLenB: len_bytes = 3'd1;
      MemLenH: len_bytes = 3'd2;
      MemLenW: len_bytes = 3'd4;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Combinational grant between fetch and load/store; prefer_if tips a tie toward fetch.
module mem_ctrl_arb (
  input  logic if_req,
  input  logic mem_req,
  input  logic flush,
  input  logic prefer_if,
  output logic grant_if,
  output logic grant_mem
);

  logic if_ok;

  // A fetch seen together with a flush is stale and never granted.
  assign if_ok     = if_req & ~flush;
  assign grant_if  = if_ok & (~mem_req | prefer_if);
  assign grant_mem = mem_req & ~(if_ok & prefer_if);

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port controller shared by fetch and load/store.
// Define MEMCTRL_RR_ARB_EN for round-robin arbitration instead of fixed load/store priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stall_req_if_o,
  output logic              stall_req_mem_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        len_q, len_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              grant_if, grant_mem, prefer_if;
  logic              last_byte, if_abort, xfer;

`ifdef MEMCTRL_RR_ARB_EN
  owner_e last_owner_q, last_owner_d;

  assign prefer_if = (last_owner_q == OwnMem);

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == StIdle) begin
      if (grant_mem) begin
        last_owner_d = OwnMem;
      end else if (grant_if) begin
        last_owner_d = OwnIf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      last_owner_q <= OwnMem;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign prefer_if = 1'b0;
`endif

  mem_ctrl_arb u_arb (
    .if_req    (if_req_i),
    .mem_req   (mem_req_i),
    .flush     (if_flush_i),
    .prefer_if (prefer_if),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  assign last_byte = (({1'b0, cnt_q} + 3'd1) == len_q);
  assign if_abort  = (owner_q == OwnIf) && if_flush_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    len_d   = len_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;

    unique case (state_q)
      StIdle: begin
        cnt_d   = 2'd0;
        owner_d = OwnNone;
        if (grant_mem) begin
          owner_d = OwnMem;
          base_d  = mem_addr_i[ADDR_W-1:0];
          len_d   = len_bytes(mem_len_i);
          we_d    = mem_we_i;
          wdata_d = mem_wdata_i;
          asm_d   = ZeroWord;
          state_d = StXfer;
        end else if (grant_if) begin
          owner_d = OwnIf;
          base_d  = if_addr_i[ADDR_W-1:0];
          len_d   = 3'd4;
          we_d    = 1'b0;
          wdata_d = ZeroWord;
          asm_d   = ZeroWord;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // RAM returns the byte one cycle late, so cycle k lands byte k-1.
        if (!we_q && (cnt_q != 2'd0)) begin
          asm_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_din_i;
        end
        if (last_byte) begin
          state_d = we_q ? StDone : StTail;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StTail: begin
        asm_d[{cnt_q, 3'b000} +: 8] = ram_din_i;
        state_d = StDone;
      end
      StDone: begin
        owner_d = OwnNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (if_abort && ((state_q == StXfer) || (state_q == StTail))) begin
      state_d = StIdle;
      owner_d = OwnNone;
      cnt_d   = 2'd0;
      asm_d   = ZeroWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      base_q  <= '0;
      len_q   <= 3'd0;
      we_q    <= 1'b0;
      wdata_q <= ZeroWord;
      cnt_q   <= 2'd0;
      asm_q   <= ZeroWord;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      len_q   <= len_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  assign xfer = (state_q == StXfer);

  always_comb begin
    ram_addr_o = '0;
    ram_dout_o = 8'h00;
    ram_wr_o   = 1'b0;
    if (xfer) begin
      ram_addr_o = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
      if (we_q) begin
        ram_wr_o   = 1'b1;
        ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
      end
    end
  end

  // A flush arriving in the done cycle still cancels the fetch result.
  assign if_done_o   = (state_q == StDone) && (owner_q == OwnIf) && !if_flush_i;
  assign mem_done_o  = (state_q == StDone) && (owner_q == OwnMem);
  assign if_data_o   = if_done_o ? asm_q : ZeroWord;
  assign mem_rdata_o = mem_done_o ? asm_q : ZeroWord;

  assign stall_req_if_o  = if_req_i & ~if_done_o;
  assign stall_req_mem_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl against a transaction-level RAM/latency model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_flush_i, mem_req_i, mem_we_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_len_i;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr_o, if_data_o, mem_rdata_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o, if_done_o, mem_done_o, stall_req_if_o, stall_req_mem_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .if_flush_i      (if_flush_i),
    .mem_req_i       (mem_req_i),
    .mem_we_i        (mem_we_i),
    .mem_len_i       (mem_len_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .ram_din_i       (ram_din),
    .ram_addr_o      (ram_addr_o),
    .ram_dout_o      (ram_dout_o),
    .ram_wr_o        (ram_wr_o),
    .if_data_o       (if_data_o),
    .if_done_o       (if_done_o),
    .mem_rdata_o     (mem_rdata_o),
    .mem_done_o      (mem_done_o),
    .stall_req_if_o  (stall_req_if_o),
    .stall_req_mem_o (stall_req_mem_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(logic [9:0] a);
    return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
  endfunction

  // Synchronous 1 KiB RAM; untouched bytes read as init_byte.
  bit [7:0] ram [1024];
  bit       ram_vld [1024];
  always @(posedge clk) begin
    if (ram_wr_o) begin
      ram[ram_addr_o[9:0]]     <= ram_dout_o;
      ram_vld[ram_addr_o[9:0]] <= 1'b1;
    end
    ram_din <= ram_vld[ram_addr_o[9:0]] ? ram[ram_addr_o[9:0]] : init_byte(ram_addr_o[9:0]);
  end

  // Reference memory image, updated only when a modelled store completes.
  bit [7:0] ref_mem [1024];
  bit       ref_vld [1024];
  bit       last_mem_m = 1'b1;
  logic [31:0] wq_a [$];
  logic [7:0]  wq_d [$];
  logic [31:0] last_if_data, last_mem_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int len_to_n(logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_vld[a[9:0]] ? ref_mem[a[9:0]] : init_byte(a[9:0]);
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] base, int nb);
    logic [31:0] r = 32'h0;
    for (int k = 0; k < nb; k++) r[8*k +: 8] = ref_rd(base + 32'(k));
    return r;
  endfunction

  task automatic ref_store(input logic [31:0] base, input int nb, input logic [31:0] wd);
    for (int k = 0; k < nb; k++) begin
      logic [31:0] a;
      a = base + 32'(k);
      ref_mem[a[9:0]] = wd[8*k +: 8];
      ref_vld[a[9:0]] = 1'b1;
    end
  endtask

  // Called with the DUT idle, #1 after a rising edge.
  task automatic run_txn(input bit want_if, input bit want_mem, input logic [31:0] if_addr,
                         input bit we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int nb, lat_mem, exp_if_n, exp_mem_n;
    bit pref_if, mem_first, if_pend, mem_pend;
    nb      = len_to_n(len);
    lat_mem = nb + (we ? 1 : 2);
`ifdef MEMCTRL_RR_ARB_EN
    pref_if = last_mem_m;
`else
    pref_if = 1'b0;
`endif
    mem_first = want_mem && !(want_if && pref_if);
    exp_if_n  = 6;
    exp_mem_n = lat_mem;
    if (want_if && want_mem) begin
      if (mem_first) exp_if_n = lat_mem + 1 + 6;
      else exp_mem_n = 6 + 1 + lat_mem;
      last_mem_m = !mem_first;
    end else begin
      last_mem_m = want_mem;
    end
    wq_a.delete();
    wq_d.delete();
    if (want_mem && we)
      for (int k = 0; k < nb; k++) begin
        wq_a.push_back(addr + 32'(k));
        wq_d.push_back(wdata[8*k +: 8]);
      end
    if_addr_i   = if_addr;
    if_req_i    = want_if;
    mem_req_i   = want_mem;
    mem_we_i    = we;
    mem_len_i   = len;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    if_pend     = want_if;
    mem_pend    = want_mem;
    for (int n = 1; n <= 40 && (if_pend || mem_pend); n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check_eq("stall_if", 32'(stall_req_if_o), 32'(want_if));
        check_eq("stall_mem", 32'(stall_req_mem_o), 32'(want_mem));
      end
      if (ram_wr_o) begin
        if (wq_a.size() == 0) check_eq("extra_wr", ram_addr_o, 32'hFFFF_FFFF);
        else begin
          check_eq("wr_addr", ram_addr_o, wq_a.pop_front());
          check_eq("wr_data", 32'(ram_dout_o), 32'(wq_d.pop_front()));
        end
      end
      if (mem_done_o) begin
        check_eq("mem_done_cyc", n, exp_mem_n);
        if (!we) check_eq("mem_rdata", mem_rdata_o, ref_load(addr, nb));
        check_eq("stall_mem_done", 32'(stall_req_mem_o), 32'h0);
        last_mem_rdata = mem_rdata_o;
        if (we) ref_store(addr, nb, wdata);
        mem_req_i = 1'b0;
        mem_pend  = 1'b0;
      end
      if (if_done_o) begin
        check_eq("if_done_cyc", n, exp_if_n);
        check_eq("if_data", if_data_o, ref_load(if_addr, 4));
        check_eq("stall_if_done", 32'(stall_req_if_o), 32'h0);
        last_if_data = if_data_o;
        if_req_i = 1'b0;
        if_pend  = 1'b0;
      end
    end
    if (if_pend) check_eq("if_timeout", 32'h1, 32'h0);
    if (mem_pend) check_eq("mem_timeout", 32'h1, 32'h0);
    check_eq("wr_left", wq_a.size(), 0);
    if_req_i  = 1'b0;
    mem_req_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Fetch aborted by a flush pulse in cycle t0+off.
  task automatic run_flush(input int off, input logic [31:0] a);
    bit seen = 1'b0;
    if_addr_i  = a;
    if_req_i   = 1'b1;
    last_mem_m = 1'b0;
    for (int n = 1; n <= off; n++) begin
      @(posedge clk);
      #1;
      if (ram_wr_o) seen = 1'b1;
    end
    if_flush_i = 1'b1;
    if_req_i   = 1'b0;
    #1;
    check_eq("flush_done_sup", 32'(if_done_o), 32'h0);
    @(posedge clk);
    #1;
    if_flush_i = 1'b0;
    check_eq("flush_idle_addr", ram_addr_o, 32'h0);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (if_done_o || ram_wr_o || (ram_addr_o != 32'h0)) seen = 1'b1;
    end
    check_eq("flush_quiet", 32'(seen), 32'h0);
  endtask

  task automatic run_reset_mid_store();
    logic [31:0] wd;
    wd          = $urandom;
    mem_addr_i  = 32'h10;
    mem_wdata_i = wd;
    mem_we_i    = 1'b1;
    mem_len_i   = 2'b10;
    mem_req_i   = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_wr0_addr", ram_addr_o, 32'h10);
    check_eq("rst_wr0_data", 32'(ram_dout_o), 32'(wd[7:0]));
    @(posedge clk);
    #1;
    check_eq("rst_wr1_addr", ram_addr_o, 32'h11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_req_i = 1'b0;
    check_eq("rst_addr", ram_addr_o, 32'h0);
    check_eq("rst_ctl", {28'h0, ram_wr_o, if_done_o, mem_done_o, 1'b0}, 32'h0);
    check_eq("rst_dout", 32'(ram_dout_o), 32'h0);
    check_eq("rst_data", if_data_o | mem_rdata_o, 32'h0);
    ref_store(32'h10, 2, wd);
    last_mem_m = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_idle_addr", ram_addr_o, 32'h0);
  endtask

  initial begin
    int mism;
    rst = 1'b1;
    if_req_i = 1'b0; if_flush_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0; mem_len_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_addr", ram_addr_o, 32'h0);
    check_eq("reset_ctl", {29'h0, ram_wr_o, if_done_o, mem_done_o}, 32'h0);
    check_eq("reset_data", if_data_o | mem_rdata_o, 32'h0);
    rst = 1'b0;

    run_txn(1'b0, 1'b1, 32'h0, 1'b1, 2'b10, 32'h100, 32'h00A0_0513);
    run_txn(1'b0, 1'b1, 32'h0, 1'b1, 2'b00, 32'h40, 32'h5566_7780);
    run_txn(1'b1, 1'b0, 32'h100, 1'b0, 2'b00, 32'h0, 32'h0);
    check_eq("if_0x100", last_if_data, 32'h00A0_0513);
    run_txn(1'b0, 1'b1, 32'h0, 1'b1, 2'b01, 32'h2001, 32'h1234_ABCD);
    run_txn(1'b1, 1'b1, 32'h0, 1'b0, 2'b00, 32'h40, 32'h0);
    check_eq("load_0x40", last_mem_rdata, 32'h0000_0080);

    for (int off = 1; off <= 6; off++) run_flush(off, {$urandom_range(0, 255), 2'b01});
    run_txn(1'b1, 1'b0, 32'h200, 1'b0, 2'b00, 32'h0, 32'h0);

    // Flush with a fresh fetch in IDLE: the fetch waits one cycle.
    if_addr_i  = 32'h304;
    if_req_i   = 1'b1;
    if_flush_i = 1'b1;
    @(posedge clk);
    #1;
    if_flush_i = 1'b0;
    check_eq("idle_flush_nogrant", ram_addr_o, 32'h0);
    run_txn(1'b1, 1'b0, 32'h304, 1'b0, 2'b00, 32'h0, 32'h0);

    // Flush held across a load is ignored.
    if_flush_i = 1'b1;
    run_txn(1'b0, 1'b1, 32'h0, 1'b0, 2'b10, 32'h2000, 32'h0);
    if_flush_i = 1'b0;

    run_reset_mid_store();

    repeat (4) run_txn(1'b1, 1'b1, $urandom, 1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom);

    for (int i = 0; i < 80; i++) begin
      bit wi, wm;
      logic [31:0] a;
      wi = 1'($urandom_range(0, 1));
      wm = 1'($urandom_range(0, 1));
      if (!wi && !wm) wm = 1'b1;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      run_txn(wi, wm, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) begin
      logic [7:0] dv, rv;
      dv = ram_vld[i] ? ram[i] : init_byte(10'(i));
      rv = ref_vld[i] ? ref_mem[i] : init_byte(10'(i));
      if (dv != rv) mism++;
    end
    check_eq("ram_image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
